// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe button front end: debounce FSM encodings,
// button bit positions and the default debounce window.
package ttt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } db_state_t;

    localparam int IDX_R   = 0;
    localparam int IDX_L   = 1;
    localparam int IDX_D   = 2;
    localparam int IDX_U   = 3;
    localparam int IDX_C   = 4;
    localparam int NUM_BTN = 5;

    // 5 ms at 100 MHz
    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/ttt_btn_debounce.sv
// One push-button: 2-flop synchronizer, debounce FSM with saturating counter,
// debounced level DPB and a one-cycle press candidate SCEN.
//
// state         | meaning
// ST_IDLE       | released and stable
// ST_DB_PRESS   | synced level high, counting toward acceptance
// ST_PRESSED    | press accepted, waiting for release
// ST_DB_RELEASE | synced level low, counting toward release
module ttt_btn_debounce
    import ttt_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic Clk,
    input  logic reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    db_state_t        state;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
            DPB   <= 1'b0;
            SCEN  <= 1'b0;
        end else begin
            sync1 <= PB;
            sync2 <= sync1;
            SCEN  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sync2) begin
                        state <= ST_DB_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!sync2) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_PRESSED;
                        DPB   <= 1'b1;
                        SCEN  <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!sync2) begin
                        state <= ST_DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                ST_DB_RELEASE: begin
                    // a bounce back high resumes the held press without a new pulse
                    if (sync2) begin
                        state <= ST_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        DPB   <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ttt_btn_conditioner.sv
// Five debounced buttons feeding the game FSM: one registered press pulse per
// cycle at most, priority C > U > D > L > R, losers dropped.
module ttt_btn_conditioner
    import ttt_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       u_BtnL,
    input  logic       u_BtnR,
    input  logic       u_BtnU,
    input  logic       u_BtnD,
    input  logic       u_BtnC,
    output logic       BtnL,
    output logic       BtnR,
    output logic       BtnU,
    output logic       BtnD,
    output logic       BtnC,
    output logic [4:0] DPB
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] scen;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] btn_q;

    assign raw[IDX_R] = u_BtnR;
    assign raw[IDX_L] = u_BtnL;
    assign raw[IDX_D] = u_BtnD;
    assign raw[IDX_U] = u_BtnU;
    assign raw[IDX_C] = u_BtnC;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        ttt_btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .Clk  (Clk),
            .reset(reset),
            .PB   (raw[i]),
            .DPB  (DPB[i]),
            .SCEN (scen[i])
        );
    end

    always_comb begin
        grant = '0;
        if (scen[IDX_C])      grant[IDX_C] = 1'b1;
        else if (scen[IDX_U]) grant[IDX_U] = 1'b1;
        else if (scen[IDX_D]) grant[IDX_D] = 1'b1;
        else if (scen[IDX_L]) grant[IDX_L] = 1'b1;
        else if (scen[IDX_R]) grant[IDX_R] = 1'b1;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) btn_q <= '0;
        else       btn_q <= grant;
    end

    assign BtnR = btn_q[IDX_R];
    assign BtnL = btn_q[IDX_L];
    assign BtnD = btn_q[IDX_D];
    assign BtnU = btn_q[IDX_U];
    assign BtnC = btn_q[IDX_C];

endmodule

// File: tb/tb_ttt_btn_conditioner.sv
// Directed bench for ttt_btn_conditioner with DB_CYCLES=4: expected pulses are
// queued when a button is driven and matched by a monitor when outputs fire.
module tb_ttt_btn_conditioner;

    localparam int DB = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       u_BtnL = 1'b0, u_BtnR = 1'b0, u_BtnU = 1'b0, u_BtnD = 1'b0, u_BtnC = 1'b0;
    logic       BtnL, BtnR, BtnU, BtnD, BtnC;
    logic [4:0] DPB;
    logic [4:0] btns;

    ttt_btn_conditioner #(.DB_CYCLES(DB)) dut (
        .Clk   (Clk),
        .reset (reset),
        .u_BtnL(u_BtnL),
        .u_BtnR(u_BtnR),
        .u_BtnU(u_BtnU),
        .u_BtnD(u_BtnD),
        .u_BtnC(u_BtnC),
        .BtnL  (BtnL),
        .BtnR  (BtnR),
        .BtnU  (BtnU),
        .BtnD  (BtnD),
        .BtnC  (BtnC),
        .DPB   (DPB)
    );

    always #5 Clk = ~Clk;

    assign btns = {BtnC, BtnU, BtnD, BtnL, BtnR};

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         at;
        logic [4:0] mask;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [4:0] mask, input string tag);
        exp_t e;
        e.at   = edge_cnt + DB + 4;
        e.mask = mask;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            step(1);
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    // Any pulse must match the oldest queued expectation in both button and cycle.
    always @(negedge Clk) begin
        if (btns !== 5'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {27'b0, btns}, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_mask"}, {27'b0, btns}, {27'b0, mon_e.mask});
                check({mon_e.tag, "_cycle"}, edge_cnt, mon_e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        step(3);
        check("reset_btns", {27'b0, btns}, 0);
        check("reset_dpb", {27'b0, DPB}, 0);
        reset = 1'b0;
        step(2);

        // clean press on R
        u_BtnR = 1'b1;
        expect_pulse(5'b00001, "clean_R");
        step(6);
        check("clean_R_dpb_early", {31'b0, DPB[0]}, 0);
        step(1);
        check("clean_R_dpb", {31'b0, DPB[0]}, 1);
        drain("clean_R", 20);
        step(10);
        u_BtnR = 1'b0;
        step(6);
        check("clean_R_rel_early", {31'b0, DPB[0]}, 1);
        step(1);
        check("clean_R_rel", {31'b0, DPB[0]}, 0);
        step(3);

        // bouncing press on U
        u_BtnU = 1'b1; step(1);
        u_BtnU = 1'b0; step(1);
        u_BtnU = 1'b1; step(1);
        u_BtnU = 1'b0; step(1);
        u_BtnU = 1'b1;
        expect_pulse(5'b01000, "bounce_U");
        drain("bounce_U", 20);
        step(10);
        check("bounce_U_dpb", {31'b0, DPB[3]}, 1);
        u_BtnU = 1'b0;
        step(10);
        check("bounce_U_idle", {27'b0, DPB}, 0);

        // long hold on C, single pulse
        u_BtnC = 1'b1;
        expect_pulse(5'b10000, "hold_C");
        step(100);
        check("hold_C_dpb", {31'b0, DPB[4]}, 1);
        check("hold_C_one_pulse", sb.size(), 0);
        u_BtnC = 1'b0;
        step(6);
        check("hold_C_rel_early", {31'b0, DPB[4]}, 1);
        step(1);
        check("hold_C_rel", {31'b0, DPB[4]}, 0);
        step(3);

        // L and C together: C wins, L dropped
        u_BtnL = 1'b1;
        u_BtnC = 1'b1;
        expect_pulse(5'b10000, "simul_CL");
        step(20);
        check("simul_CL_dpb", {27'b0, DPB}, 32'h12);
        drain("simul_CL", 5);
        u_BtnL = 1'b0;
        u_BtnC = 1'b0;
        step(10);
        check("simul_CL_idle", {27'b0, DPB}, 0);

        // release glitch on L must not re-trigger or drop DPB
        u_BtnL = 1'b1;
        expect_pulse(5'b00010, "glitch_L");
        step(12);
        drain("glitch_L", 5);
        u_BtnL = 1'b0;
        step(2);
        u_BtnL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("glitch_L_dpb", {31'b0, DPB[1]}, 1);
        end
        u_BtnL = 1'b0;
        step(10);
        check("glitch_L_idle", {27'b0, DPB}, 0);

        // reset mid-debounce of D while R is held; both held through release
        u_BtnR = 1'b1;
        expect_pulse(5'b00001, "pre_rst_R");
        step(12);
        drain("pre_rst_R", 5);
        u_BtnD = 1'b1;
        step(2);
        reset = 1'b1;
        #1;
        check("rst_async_btns", {27'b0, btns}, 0);
        check("rst_async_dpb", {27'b0, DPB}, 0);
        step(3);
        check("rst_hold_dpb", {27'b0, DPB}, 0);
        reset = 1'b0;
        expect_pulse(5'b00100, "post_rst_D");
        step(6);
        check("post_rst_dpb_early", {27'b0, DPB}, 0);
        step(14);
        check("post_rst_dpb", {27'b0, DPB}, 32'h05);
        drain("post_rst_D", 5);
        u_BtnD = 1'b0;
        u_BtnR = 1'b0;
        step(12);
        check("final_idle", {27'b0, DPB}, 0);
        check("final_queue", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ttt_btn_conditioner.md
TTT_BTN_CONDITIONER -- requirements
Module: ttt_btn_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set the number of consecutive stable Clk cycles required to accept a press or release (5 ms at 100 MHz); legal range 2..2^20.
REQ-002 Clk  input  1  SHALL be the system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 u_BtnL, u_BtnR, u_BtnU, u_BtnD, u_BtnC  input  1 each  SHALL be the raw, asynchronous, bouncing push-button levels (1 = pressed).
REQ-005 BtnL, BtnR, BtnU, BtnD, BtnC  output  1 each  SHALL be single-cycle press pulses that feed the game FSM's cursor-move and place inputs.
REQ-006 DPB  output  5  SHALL carry the debounced button levels {C,U,D,L,R} (bit4 = C … bit0 = R).

Function
REQ-007 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-008 Each button SHALL run an independent FSM with states IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-009 IDLE: a synced level of 1 SHALL move the FSM to DB_PRESS and clear the counter.
REQ-010 DB_PRESS: while the synced level is 1, the counter SHALL increment; a synced 0 SHALL return the FSM to IDLE with the counter cleared (bounce reject).
REQ-011 When the counter reaches DB_CYCLES-1 with the synced level still 1, the FSM SHALL go to PRESSED and raise that button's candidate pulse for exactly that one transition cycle.
REQ-012 PRESSED: a synced 0 SHALL move the FSM to DB_RELEASE and clear the counter; holding the button SHALL NOT generate further pulses (no auto-repeat).
REQ-013 DB_RELEASE: a synced 1 SHALL return the FSM to PRESSED without a pulse; DB_CYCLES consecutive 0s SHALL return it to IDLE.
REQ-014 The DPB bit SHALL be 1 in PRESSED and DB_RELEASE, and 0 otherwise.
REQ-015 Latency: if a raw input rises and stays high, the candidate pulse SHALL appear exactly DB_CYCLES+3 Clk cycles after the first edge that samples it high.
REQ-016 Arbitration: at most one output pulse SHALL be high in any cycle. When several candidates coincide, priority SHALL be C > U > D > L > R; lower-priority candidates in that cycle are dropped, not deferred.
REQ-017 Outputs BtnX SHALL be registered: the arbitrated pulse is asserted on the cycle after the candidate.
REQ-018 The counter SHALL be clog2(DB_CYCLES) bits wide and SHALL saturate; it never wraps.

Reset
REQ-019 While reset is high, all FSMs SHALL be in IDLE, counters and synchronizers SHALL be 0, and all BtnX and DPB outputs SHALL be 0, independent of Clk.
REQ-020 A button held through reset deassertion SHALL be treated as a new press and SHALL produce one pulse after the REQ-015 latency.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that attempt.

Structure
REQ-022 Constants SHALL live in the shared package ttt_pkg: the 2-bit FSM state encodings, button index constants (IDX_R=0 … IDX_C=4), and the default DB_CYCLES.
REQ-023 The per-button synchronizer, FSM and counter SHALL be a sub-module ttt_btn_debounce (ports Clk, reset, PB, DPB, SCEN), instantiated five times.
REQ-024 Arbitration and output registers SHALL reside in the top module.

Verification (bench uses DB_CYCLES=4)
REQ-025 Clean press: u_BtnR held high from cycle 0 -> BtnR is high only in cycle 8 (7 cycles to candidate plus 1 registered cycle); DPB[0]=1 from cycle 7.
REQ-026 Bounce: u_BtnU toggles 1,0,1,0 on successive cycles, then holds 1 -> exactly one BtnU pulse, 8 cycles after the last rising edge.
REQ-027 Hold: u_BtnC held high for 100 cycles -> exactly one BtnC pulse; after release, DPB[4] returns to 0 seven cycles later.
REQ-028 Simultaneous: u_BtnL and u_BtnC rise in the same cycle -> only BtnC pulses; BtnL stays 0 for the whole press.
REQ-029 Reset mid-operation: reset asserted 2 cycles into a u_BtnD press and released with u_BtnD still high -> all outputs go to 0 immediately; one BtnD pulse occurs 8 cycles after reset release.
REQ-030 Release glitch: after u_BtnL is accepted, a 2-cycle low glitch -> no second BtnL pulse, and DPB[1] stays 1.
